// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
//
// Decode stage of a five-stage RV32I pipeline. It owns the IF/ID pipeline
// register and decodes the held instruction into control fields plus a
// sign-extended immediate. The result is registered into the ID/EX boundary.
// A load in ID/EX whose destination is read by the instruction in IF/ID
// stalls fetch for one cycle and inserts a bubble. The EX-stage redirect
// (flush) empties both pipeline registers and takes priority over the stall.
//
// Flow control: a fetched instruction is accepted at a rising edge only when
// pc_en is 1 at that edge. pc_en acts as the "ready" of the fetch stage, and
// every cycle is implicitly "valid" from fetch. valid_ex qualifies every *_ex
// field. When valid_ex is 0, all control flags are 0, and the remaining
// fields carry no meaning.
//
// Ports:
//   clk            in   pipeline clock, all state changes on the rising edge
//   reset          in   synchronous, active-high reset
//   instruction_if in   instruction fetched this cycle
//   pc_if          in   PC of instruction_if
//   flush          in   taken branch / jump redirect from EX
//   pc_en          out  fetch PC enable, 0 during a load-use stall
//   valid_ex       out  ID/EX holds a real instruction
//   pc_ex          out  PC of the ID/EX instruction
//   op_class_ex    out  instruction class (0 = none/bubble, 15 = illegal)
//   rd_ex/rs1_ex/rs2_ex  out  register indices
//   funct3_ex      out  instr[14:12]
//   funct7b5_ex    out  instr[30]
//   imm_ex         out  sign-extended immediate
//   reg_write_ex, mem_read_ex, mem_write_ex, illegal_ex  out  control flags
//   stall_cycles   out  saturating count of cycles with pc_en = 0
// -----------------------------------------------------------------------------
module id_stage #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16,
   parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           instruction_if,
   input  logic [DATA_WIDTH-1:0] pc_if,
   input  logic                  flush,
   output logic                  pc_en,
   output logic                  valid_ex,
   output logic [DATA_WIDTH-1:0] pc_ex,
   output logic [3:0]            op_class_ex,
   output logic [4:0]            rd_ex,
   output logic [4:0]            rs1_ex,
   output logic [4:0]            rs2_ex,
   output logic [2:0]            funct3_ex,
   output logic                  funct7b5_ex,
   output logic [DATA_WIDTH-1:0] imm_ex,
   output logic                  reg_write_ex,
   output logic                  mem_read_ex,
   output logic                  mem_write_ex,
   output logic                  illegal_ex,
   output logic [CNT_WIDTH-1:0]  stall_cycles
);

   // Instruction classes
   localparam logic [3:0] CLS_NONE    = 4'd0;
   localparam logic [3:0] CLS_LUI     = 4'd1;
   localparam logic [3:0] CLS_AUIPC   = 4'd2;
   localparam logic [3:0] CLS_JAL     = 4'd3;
   localparam logic [3:0] CLS_JALR    = 4'd4;
   localparam logic [3:0] CLS_BRANCH  = 4'd5;
   localparam logic [3:0] CLS_LOAD    = 4'd6;
   localparam logic [3:0] CLS_STORE   = 4'd7;
   localparam logic [3:0] CLS_OPIMM   = 4'd8;
   localparam logic [3:0] CLS_OP      = 4'd9;
   localparam logic [3:0] CLS_ILLEGAL = 4'd15;

   // Major opcodes
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_FENCE   = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

   // ID/EX boundary contents; an all-zero value is a bubble.
   typedef struct packed {
      logic                  valid;
      logic [DATA_WIDTH-1:0] pc;
      logic [3:0]            op_class;
      logic [4:0]            rd;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [2:0]            funct3;
      logic                  funct7b5;
      logic [DATA_WIDTH-1:0] imm;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic                  illegal;
   } idex_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [31:0]           ifid_instr_q, ifid_instr_d;
   logic [DATA_WIDTH-1:0] ifid_pc_q,    ifid_pc_d;
   logic                  ifid_valid_q, ifid_valid_d;
   idex_t                 idex_q,       idex_d;
   logic [CNT_WIDTH-1:0]  stall_q,      stall_d;

   // ---------------------------------------------------------------------
   // Decode of the IF/ID instruction
   // ---------------------------------------------------------------------
   logic [6:0]            dec_opcode;
   logic [4:0]            dec_rd;
   logic [4:0]            dec_rs1;
   logic [4:0]            dec_rs2;
   logic [2:0]            dec_funct3;
   logic                  dec_funct7b5;
   logic [3:0]            dec_class;
   logic [31:0]           dec_imm32;
   logic [DATA_WIDTH-1:0] dec_imm;
   logic                  dec_uses_rs1;
   logic                  dec_uses_rs2;
   logic                  dec_reg_write;
   logic                  dec_mem_read;
   logic                  dec_mem_write;
   logic                  dec_illegal;
   logic                  hazard;

   assign dec_opcode   = ifid_instr_q[6:0];
   assign dec_rd       = ifid_instr_q[11:7];
   assign dec_funct3   = ifid_instr_q[14:12];
   assign dec_rs1      = ifid_instr_q[19:15];
   assign dec_rs2      = ifid_instr_q[24:20];
   assign dec_funct7b5 = ifid_instr_q[30];

   // Opcode to class. FENCE and SYSTEM are legal but have no side effects
   // in this pipeline, so they share class 0 with the bubble.
   always_comb begin
      dec_class   = CLS_ILLEGAL;
      dec_illegal = 1'b0;
      unique case (dec_opcode)
         OPC_LUI:    dec_class = CLS_LUI;
         OPC_AUIPC:  dec_class = CLS_AUIPC;
         OPC_JAL:    dec_class = CLS_JAL;
         OPC_JALR:   dec_class = CLS_JALR;
         OPC_BRANCH: dec_class = CLS_BRANCH;
         OPC_LOAD:   dec_class = CLS_LOAD;
         OPC_STORE:  dec_class = CLS_STORE;
         OPC_OPIMM:  dec_class = CLS_OPIMM;
         OPC_OP:     dec_class = CLS_OP;
         OPC_FENCE:  dec_class = CLS_NONE;
         OPC_SYSTEM: dec_class = CLS_NONE;
         default: begin
            dec_class   = CLS_ILLEGAL;
            dec_illegal = 1'b1;
         end
      endcase
   end

   // Immediate assembly. Every format takes its sign from instr[31].
   always_comb begin
      dec_imm32 = 32'd0;
      unique case (dec_class)
         CLS_JALR, CLS_LOAD, CLS_OPIMM:
            dec_imm32 = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
         CLS_STORE:
            dec_imm32 = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25],
                         ifid_instr_q[11:7]};
         CLS_BRANCH:
            dec_imm32 = {{19{ifid_instr_q[31]}}, ifid_instr_q[31],
                         ifid_instr_q[7], ifid_instr_q[30:25],
                         ifid_instr_q[11:8], 1'b0};
         CLS_LUI, CLS_AUIPC:
            dec_imm32 = {ifid_instr_q[31:12], 12'd0};
         CLS_JAL:
            dec_imm32 = {{11{ifid_instr_q[31]}}, ifid_instr_q[31],
                         ifid_instr_q[19:12], ifid_instr_q[20],
                         ifid_instr_q[30:21], 1'b0};
         default:
            dec_imm32 = 32'd0;
      endcase
   end

   // Widen to the datapath, keeping the sign.
   assign dec_imm = DATA_WIDTH'($signed(dec_imm32));

   assign dec_uses_rs1 = dec_class inside {CLS_JALR, CLS_BRANCH, CLS_LOAD,
                                           CLS_STORE, CLS_OPIMM, CLS_OP};
   assign dec_uses_rs2 = dec_class inside {CLS_BRANCH, CLS_STORE, CLS_OP};

   // Writes to x0 are discarded, so they never count as register writes.
   assign dec_reg_write = (dec_class inside {CLS_LUI, CLS_AUIPC, CLS_JAL,
                                             CLS_JALR, CLS_LOAD, CLS_OPIMM,
                                             CLS_OP})
                          && (dec_rd != 5'd0);
   assign dec_mem_read  = (dec_class == CLS_LOAD);
   assign dec_mem_write = (dec_class == CLS_STORE);

   // ---------------------------------------------------------------------
   // Load-use hazard: the load in ID/EX produces its data too late for the
   // instruction in IF/ID. A load to x0 never creates a dependency.
   // ---------------------------------------------------------------------
   assign hazard = ifid_valid_q && idex_q.valid && idex_q.mem_read
                   && (idex_q.rd != 5'd0)
                   && ((dec_uses_rs1 && (dec_rs1 == idex_q.rd))
                       || (dec_uses_rs2 && (dec_rs2 == idex_q.rd)));

   // A redirect discards the stalled instruction anyway, so flush releases
   // fetch even when a hazard is present.
   assign pc_en = !(hazard && !flush);

   // ---------------------------------------------------------------------
   // IF/ID register
   // ---------------------------------------------------------------------
   always_comb begin
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_valid_d = ifid_valid_q;
      if (flush) begin
         ifid_instr_d = NOP_INSTR;
         ifid_pc_d    = '0;
         ifid_valid_d = 1'b0;
      end else if (!hazard) begin
         ifid_instr_d = instruction_if;
         ifid_pc_d    = pc_if;
         ifid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ifid_instr_q <= NOP_INSTR;
         ifid_pc_q    <= '0;
         ifid_valid_q <= 1'b0;
      end else begin
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   // ---------------------------------------------------------------------
   // ID/EX register. Flush and hazard both insert a bubble. An empty IF/ID
   // still passes its decoded fields through, but with every flag cleared.
   // ---------------------------------------------------------------------
   always_comb begin
      idex_d = '0;
      if (!flush && !hazard) begin
         idex_d.valid     = ifid_valid_q;
         idex_d.pc        = ifid_pc_q;
         idex_d.op_class  = dec_class;
         idex_d.rd        = dec_rd;
         idex_d.rs1       = dec_rs1;
         idex_d.rs2       = dec_rs2;
         idex_d.funct3    = dec_funct3;
         idex_d.funct7b5  = dec_funct7b5;
         idex_d.imm       = dec_imm;
         idex_d.reg_write = dec_reg_write && ifid_valid_q;
         idex_d.mem_read  = dec_mem_read  && ifid_valid_q;
         idex_d.mem_write = dec_mem_write && ifid_valid_q;
         idex_d.illegal   = dec_illegal   && ifid_valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idex_q <= '0;
      end else begin
         idex_q <= idex_d;
      end
   end

   // ---------------------------------------------------------------------
   // Stall-cycle counter, saturating at all-ones.
   // ---------------------------------------------------------------------
   always_comb begin
      stall_d = stall_q;
      if (!pc_en && (stall_q != {CNT_WIDTH{1'b1}})) begin
         stall_d = stall_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign valid_ex     = idex_q.valid;
   assign pc_ex        = idex_q.pc;
   assign op_class_ex  = idex_q.op_class;
   assign rd_ex        = idex_q.rd;
   assign rs1_ex       = idex_q.rs1;
   assign rs2_ex       = idex_q.rs2;
   assign funct3_ex    = idex_q.funct3;
   assign funct7b5_ex  = idex_q.funct7b5;
   assign imm_ex       = idex_q.imm;
   assign reg_write_ex = idex_q.reg_write;
   assign mem_read_ex  = idex_q.mem_read;
   assign mem_write_ex = idex_q.mem_write;
   assign illegal_ex   = idex_q.illegal;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
//
// Self-checking bench for id_stage. A behavioural model of the two pipeline
// registers is stepped once per clock and compared with the DUT every cycle.
// Decode vectors with hand-derived expectations and short hand-written
// sequences cover the stall, flush, x0, reset and saturation cases. The
// stall counter is narrowed so that saturation is reachable.
// -----------------------------------------------------------------------------
module tb_id_stage;

   localparam int CW = 4;
   localparam int SAT = (1 << CW) - 1;
   localparam logic [31:0] NOP = 32'h00000013;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   instruction_if;
   logic [31:0]   pc_if;
   logic          flush;
   logic          pc_en;
   logic          valid_ex;
   logic [31:0]   pc_ex;
   logic [3:0]    op_class_ex;
   logic [4:0]    rd_ex, rs1_ex, rs2_ex;
   logic [2:0]    funct3_ex;
   logic          funct7b5_ex;
   logic [31:0]   imm_ex;
   logic          reg_write_ex, mem_read_ex, mem_write_ex, illegal_ex;
   logic [CW-1:0] stall_cycles;

   int errors = 0;
   int checks = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   id_stage #(
      .DATA_WIDTH (32),
      .CNT_WIDTH  (CW),
      .NOP_INSTR  (NOP)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .instruction_if (instruction_if),
      .pc_if          (pc_if),
      .flush          (flush),
      .pc_en          (pc_en),
      .valid_ex       (valid_ex),
      .pc_ex          (pc_ex),
      .op_class_ex    (op_class_ex),
      .rd_ex          (rd_ex),
      .rs1_ex         (rs1_ex),
      .rs2_ex         (rs2_ex),
      .funct3_ex      (funct3_ex),
      .funct7b5_ex    (funct7b5_ex),
      .imm_ex         (imm_ex),
      .reg_write_ex   (reg_write_ex),
      .mem_read_ex    (mem_read_ex),
      .mem_write_ex   (mem_write_ex),
      .illegal_ex     (illegal_ex),
      .stall_cycles   (stall_cycles)
   );

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [3:0]  cls;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic        f7;
      logic [31:0] imm;
      logic        rw, mr, mw, ill;
   } ex_m_t;

   logic        m_if_valid;
   logic [31:0] m_if_instr;
   logic [31:0] m_if_pc;
   ex_m_t       m_ex;
   int          m_stall;

   function automatic ex_m_t decode_m(logic [31:0] ins, logic [31:0] pc, logic v);
      ex_m_t r;
      int s, b7, b20, hi6, lo4, mid8, mid10;
      s = ins;
      b7 = ins[7];
      b20 = ins[20];
      hi6 = ins[30:25];
      lo4 = ins[11:8];
      mid8 = ins[19:12];
      mid10 = ins[30:21];
      r = '0;
      case (ins[6:0])
         7'b0110111: r.cls = 1;
         7'b0010111: r.cls = 2;
         7'b1101111: r.cls = 3;
         7'b1100111: r.cls = 4;
         7'b1100011: r.cls = 5;
         7'b0000011: r.cls = 6;
         7'b0100011: r.cls = 7;
         7'b0010011: r.cls = 8;
         7'b0110011: r.cls = 9;
         7'b0001111, 7'b1110011: r.cls = 0;
         default: r.cls = 15;
      endcase
      case (r.cls)
         4, 6, 8: r.imm = s >>> 20;
         7:       r.imm = (s >>> 25) * 32 + int'(ins[11:7]);
         5:       r.imm = (s >>> 31) * 4096 + b7 * 2048 + hi6 * 32 + lo4 * 2;
         1, 2:    r.imm = ins & 32'hFFFFF000;
         3:       r.imm = (s >>> 31) * 1048576 + mid8 * 4096 + b20 * 2048 + mid10 * 2;
         default: r.imm = 0;
      endcase
      r.valid = v;
      r.pc    = pc;
      r.rd    = ins[11:7];
      r.rs1   = ins[19:15];
      r.rs2   = ins[24:20];
      r.f3    = ins[14:12];
      r.f7    = ins[30];
      r.rw    = v && (r.cls inside {1, 2, 3, 4, 6, 8, 9}) && (r.rd != 0);
      r.mr    = v && (r.cls == 6);
      r.mw    = v && (r.cls == 7);
      r.ill   = v && (r.cls == 15);
      return r;
   endfunction

   function automatic bit hazard_m();
      ex_m_t d;
      d = decode_m(m_if_instr, m_if_pc, m_if_valid);
      return m_if_valid && m_ex.valid && m_ex.mr && (m_ex.rd != 0)
             && (((d.cls inside {4, 5, 6, 7, 8, 9}) && d.rs1 == m_ex.rd)
                 || ((d.cls inside {5, 7, 9}) && d.rs2 == m_ex.rd));
   endfunction

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver: one clock cycle ----------------
   // Drives inputs at the falling edge, compares against the model, then
   // advances the model to its state after the next rising edge.
   task automatic cycle(input logic rst, input logic fl, input logic [31:0] ins,
                        input logic [31:0] pc);
      bit h;
      @(negedge clk);
      reset = rst;
      flush = fl;
      instruction_if = ins;
      pc_if = pc;
      #1;
      h = hazard_m();
      chk("pc_en", pc_en, !(h && !fl));
      chk("valid_ex", valid_ex, m_ex.valid);
      chk("reg_write_ex", reg_write_ex, m_ex.rw);
      chk("mem_read_ex", mem_read_ex, m_ex.mr);
      chk("mem_write_ex", mem_write_ex, m_ex.mw);
      chk("illegal_ex", illegal_ex, m_ex.ill);
      chk("stall_cycles", stall_cycles, m_stall);
      if (m_ex.valid) begin
         chk("pc_ex", pc_ex, m_ex.pc);
         chk("op_class_ex", op_class_ex, m_ex.cls);
         chk("rd_ex", rd_ex, m_ex.rd);
         chk("rs1_ex", rs1_ex, m_ex.rs1);
         chk("rs2_ex", rs2_ex, m_ex.rs2);
         chk("funct3_ex", funct3_ex, m_ex.f3);
         chk("funct7b5_ex", funct7b5_ex, m_ex.f7);
         chk("imm_ex", imm_ex, m_ex.imm);
      end
      if (rst) begin
         m_if_valid = 1'b0;
         m_if_instr = NOP;
         m_if_pc = 0;
         m_ex = '0;
         m_stall = 0;
      end else begin
         if (h && !fl && m_stall < SAT) m_stall++;
         if (fl || h) m_ex = '0;
         else m_ex = decode_m(m_if_instr, m_if_pc, m_if_valid);
         if (fl) begin
            m_if_valid = 1'b0;
            m_if_instr = NOP;
            m_if_pc = 0;
         end else if (!h) begin
            m_if_valid = 1'b1;
            m_if_instr = ins;
            m_if_pc = pc;
         end
      end
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, NOP, 32'h0);
      cycle(1'b1, 1'b0, NOP, 32'h0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      ins = $urandom;
      case ($urandom_range(0, 12))
         0:       ins[6:0] = 7'b0110111;
         1:       ins[6:0] = 7'b0010111;
         2:       ins[6:0] = 7'b1101111;
         3:       ins[6:0] = 7'b1100111;
         4:       ins[6:0] = 7'b1100011;
         5, 6, 7: ins[6:0] = 7'b0000011;
         8:       ins[6:0] = 7'b0100011;
         9:       ins[6:0] = 7'b0010011;
         10:      ins[6:0] = 7'b0110011;
         11:      ins[6:0] = ($urandom_range(0, 1) != 0) ? 7'b0001111 : 7'b1110011;
         default: ins[6:0] = ins[6:0];
      endcase
      // Small register numbers make dependencies frequent.
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      return ins;
   endfunction

   // ---------------- decode vectors ----------------
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [3:0]  cls;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        rw, mr, mw, ill;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs[NV];

   localparam logic [31:0] LW_X2   = 32'h0000A103;  // lw  x2,0(x1)
   localparam logic [31:0] ADD_X2  = 32'h002101B3;  // add x3,x2,x2
   localparam logic [31:0] LW_X0   = 32'h0000A003;  // lw  x0,0(x1)
   localparam logic [31:0] ADD_X0  = 32'h000001B3;  // add x3,x0,x0

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      instruction_if = NOP;
      pc_if = 32'h0;
      m_if_valid = 1'b0;
      m_if_instr = NOP;
      m_if_pc = 0;
      m_ex = '0;
      m_stall = 0;

      vecs[0]  = '{32'h00500093, 32'h200, 4'd8,  5'd1,  32'h00000005, 1, 0, 0, 0};
      vecs[1]  = '{32'hFE000EE3, 32'h204, 4'd5,  5'd29, 32'hFFFFFFFC, 0, 0, 0, 0};
      vecs[2]  = '{32'h123450B7, 32'h208, 4'd1,  5'd1,  32'h12345000, 1, 0, 0, 0};
      vecs[3]  = '{32'h0020A423, 32'h20C, 4'd7,  5'd8,  32'h00000008, 0, 0, 1, 0};
      vecs[4]  = '{32'hFF9FF0EF, 32'h210, 4'd3,  5'd1,  32'hFFFFFFF8, 1, 0, 0, 0};
      vecs[5]  = '{32'hFFFFFFFF, 32'h214, 4'd15, 5'd31, 32'h00000000, 0, 0, 0, 1};
      vecs[6]  = '{32'h0000000F, 32'h218, 4'd0,  5'd0,  32'h00000000, 0, 0, 0, 0};
      vecs[7]  = '{32'hFFF32283, 32'h21C, 4'd6,  5'd5,  32'hFFFFFFFF, 1, 1, 0, 0};
      vecs[8]  = '{32'h00001017, 32'h220, 4'd2,  5'd0,  32'h00001000, 0, 0, 0, 0};
      vecs[9]  = '{32'h002101B3, 32'h224, 4'd9,  5'd3,  32'h00000000, 1, 0, 0, 0};
      vecs[10] = '{32'h004100E7, 32'h228, 4'd4,  5'd1,  32'h00000004, 1, 0, 0, 0};
      vecs[11] = '{32'h00000073, 32'h22C, 4'd0,  5'd0,  32'h00000000, 0, 0, 0, 0};

      // Reset with an illegal word on the fetch port.
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, 1'b0, 32'hFFFFFFFF, 32'h100);
         chk("rst_valid_ex", valid_ex, 0);
         chk("rst_pc_en", pc_en, 1);
         chk("rst_stall", stall_cycles, 0);
         chk("rst_illegal", illegal_ex, 0);
         chk("rst_class", op_class_ex, 0);
      end

      // Decode table: each vector reaches the *_ex outputs two cycles later.
      for (int i = 0; i < NV; i++) begin
         cycle(1'b0, 1'b0, vecs[i].instr, vecs[i].pc);
         cycle(1'b0, 1'b0, NOP, vecs[i].pc + 32'h100);
         cycle(1'b0, 1'b0, NOP, vecs[i].pc + 32'h104);
         chk("vec_valid", valid_ex, 1);
         chk("vec_pc", pc_ex, vecs[i].pc);
         chk("vec_class", op_class_ex, vecs[i].cls);
         chk("vec_rd", rd_ex, vecs[i].rd);
         chk("vec_imm", imm_ex, vecs[i].imm);
         chk("vec_reg_write", reg_write_ex, vecs[i].rw);
         chk("vec_mem_read", mem_read_ex, vecs[i].mr);
         chk("vec_mem_write", mem_write_ex, vecs[i].mw);
         chk("vec_illegal", illegal_ex, vecs[i].ill);
      end

      // Load-use stall: one stall cycle, one bubble, then the add.
      do_reset();
      cycle(1'b0, 1'b0, LW_X2, 32'h300);
      cycle(1'b0, 1'b0, ADD_X2, 32'h304);
      chk("lu_pc_en_before", pc_en, 1);
      cycle(1'b0, 1'b0, NOP, 32'h308);
      chk("lu_pc_en_stall", pc_en, 0);
      chk("lu_lw_in_ex", mem_read_ex, 1);
      cycle(1'b0, 1'b0, NOP, 32'h308);
      chk("lu_pc_en_after", pc_en, 1);
      chk("lu_bubble", valid_ex, 0);
      chk("lu_stall_count", stall_cycles, 1);
      cycle(1'b0, 1'b0, NOP, 32'h30C);
      chk("lu_add_valid", valid_ex, 1);
      chk("lu_add_class", op_class_ex, 9);
      chk("lu_add_pc", pc_ex, 32'h304);
      chk("lu_stall_final", stall_cycles, 1);

      // Flush in the hazard cycle wins over the stall.
      do_reset();
      cycle(1'b0, 1'b0, LW_X2, 32'h400);
      cycle(1'b0, 1'b0, ADD_X2, 32'h404);
      cycle(1'b0, 1'b1, NOP, 32'h408);
      chk("fl_pc_en", pc_en, 1);
      cycle(1'b0, 1'b0, NOP, 32'h500);
      chk("fl_valid_1", valid_ex, 0);
      cycle(1'b0, 1'b0, NOP, 32'h504);
      chk("fl_valid_2", valid_ex, 0);
      chk("fl_stall", stall_cycles, 0);
      cycle(1'b0, 1'b0, NOP, 32'h508);
      chk("fl_resume_pc", pc_ex, 32'h500);

      // A load to x0 never stalls.
      do_reset();
      cycle(1'b0, 1'b0, LW_X0, 32'h600);
      cycle(1'b0, 1'b0, ADD_X0, 32'h604);
      cycle(1'b0, 1'b0, NOP, 32'h608);
      chk("x0_pc_en", pc_en, 1);
      cycle(1'b0, 1'b0, NOP, 32'h60C);
      chk("x0_add_class", op_class_ex, 9);
      chk("x0_stall", stall_cycles, 0);

      // Reset in the stall cycle releases fetch with an empty IF/ID.
      do_reset();
      cycle(1'b0, 1'b0, LW_X2, 32'h700);
      cycle(1'b0, 1'b0, ADD_X2, 32'h704);
      cycle(1'b1, 1'b0, NOP, 32'h708);
      cycle(1'b0, 1'b0, NOP, 32'h708);
      chk("rs_pc_en", pc_en, 1);
      chk("rs_valid", valid_ex, 0);
      chk("rs_stall", stall_cycles, 0);
      cycle(1'b0, 1'b0, NOP, 32'h70C);
      chk("rs_empty_ifid", valid_ex, 0);

      // Saturation: 20 separate load-use stalls on a 4-bit counter.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 1'b0, LW_X2, 32'h800);
         cycle(1'b0, 1'b0, ADD_X2, 32'h804);
         cycle(1'b0, 1'b0, NOP, 32'h808);
         cycle(1'b0, 1'b0, NOP, 32'h808);
      end
      chk("sat_stall", stall_cycles, SAT);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
               rand_instr(), 32'h1000 + 32'(i) * 4);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
